// File: rtl/copiador_memoria.sv
// -----------------------------------------------------------------------------
// copiador_memoria
//
// Block copier that drives a single-port data memory. Once started it moves
// `tamanho` words from `origem` to `destino`, one word at a time, in
// ascending order, using a read cycle followed by a write cycle on the
// shared memory port. Every generated address wraps modulo PROFUNDIDADE.
//
// Ports:
//   clock            rising-edge clock shared with the memory
//   reset            asynchronous, active-high reset
//   iniciar          start request, only honoured while idle
//   origem           source base address, captured at start
//   destino          destination base address, captured at start
//   tamanho          number of words to copy, captured at start
//   mem_dado_leitura memory read data (asynchronous read of mem_endereco)
//   mem_endereco     memory address (upper bits always zero)
//   mem_escrever     memory write enable, memory writes on the clock edge
//   mem_dado_escrita memory write data (the word buffered by the last read)
//   ocupado          high whenever a transfer is in progress
//   pronto           one-cycle completion pulse
//   contagem         words written so far in the current or last transfer
// -----------------------------------------------------------------------------
module copiador_memoria #(
    parameter int LARGURA      = 16,
    parameter int PROFUNDIDADE = 64,
    parameter int LARGURA_CONT = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [15:0]             origem,
    input  logic [15:0]             destino,
    input  logic [LARGURA_CONT-1:0] tamanho,
    input  logic [LARGURA-1:0]      mem_dado_leitura,
    output logic [15:0]             mem_endereco,
    output logic                    mem_escrever,
    output logic [LARGURA-1:0]      mem_dado_escrita,
    output logic                    ocupado,
    output logic                    pronto,
    output logic [LARGURA_CONT-1:0] contagem
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LER      = 2'd1,
        ESCREVER = 2'd2,
        FIM      = 2'd3
    } estado_t;

    estado_t                 estado_r;
    estado_t                 proximo_s;

    logic [15:0]             origem_r;
    logic [15:0]             destino_r;
    logic [LARGURA_CONT-1:0] tamanho_r;
    logic [LARGURA_CONT-1:0] indice_r;
    logic [LARGURA_CONT-1:0] contagem_r;
    logic [LARGURA-1:0]      buffer_r;

    logic [15:0]             endereco_s;
    logic                    ultimo_s;

    // (base + offset) mod PROFUNDIDADE; the 17-bit sum keeps the carry so the
    // wrap is correct even when the base has upper bits set.
    function automatic logic [15:0] endereco_circular(
        input logic [15:0]             base,
        input logic [LARGURA_CONT-1:0] deslocamento
    );
        logic [16:0] soma;
        soma = {1'b0, base} + {{(17-LARGURA_CONT){1'b0}}, deslocamento};
        return 16'(soma % 17'(PROFUNDIDADE));
    endfunction

    // The word being written is the last one of the transfer.
    assign ultimo_s = ((indice_r + LARGURA_CONT'(1)) == tamanho_r);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= proximo_s;
        end
    end

    // Next-state logic.
    always_comb begin
        proximo_s = estado_r;
        case (estado_r)
            OCIOSO: begin
                if (iniciar) begin
                    if (tamanho != {LARGURA_CONT{1'b0}}) begin
                        proximo_s = LER;
                    end else begin
                        proximo_s = FIM;
                    end
                end else begin
                    proximo_s = OCIOSO;
                end
            end
            LER: begin
                proximo_s = ESCREVER;
            end
            ESCREVER: begin
                if (ultimo_s) begin
                    proximo_s = FIM;
                end else begin
                    proximo_s = LER;
                end
            end
            FIM: begin
                proximo_s = OCIOSO;
            end
            default: begin
                proximo_s = OCIOSO;
            end
        endcase
    end

    // Transfer registers: parameter capture, read buffer, index and count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            origem_r   <= 16'd0;
            destino_r  <= 16'd0;
            tamanho_r  <= {LARGURA_CONT{1'b0}};
            indice_r   <= {LARGURA_CONT{1'b0}};
            contagem_r <= {LARGURA_CONT{1'b0}};
            buffer_r   <= {LARGURA{1'b0}};
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (iniciar) begin
                        origem_r   <= origem;
                        destino_r  <= destino;
                        tamanho_r  <= tamanho;
                        indice_r   <= {LARGURA_CONT{1'b0}};
                        contagem_r <= {LARGURA_CONT{1'b0}};
                    end else begin
                        origem_r   <= origem_r;
                        destino_r  <= destino_r;
                        tamanho_r  <= tamanho_r;
                        indice_r   <= indice_r;
                        contagem_r <= contagem_r;
                    end
                end
                LER: begin
                    buffer_r <= mem_dado_leitura;
                end
                ESCREVER: begin
                    indice_r   <= indice_r + LARGURA_CONT'(1);
                    contagem_r <= contagem_r + LARGURA_CONT'(1);
                end
                default: begin
                    buffer_r <= buffer_r;
                end
            endcase
        end
    end

    // Address generation: source during the read cycle, destination during
    // the write cycle, zero otherwise.
    always_comb begin
        endereco_s = 16'd0;
        case (estado_r)
            LER: begin
                endereco_s = endereco_circular(origem_r, indice_r);
            end
            ESCREVER: begin
                endereco_s = endereco_circular(destino_r, indice_r);
            end
            default: begin
                endereco_s = 16'd0;
            end
        endcase
    end

    // Outputs are decodes of registered state only, so reset drops the
    // write enable immediately and iniciar never reaches the memory port.
    assign mem_endereco     = endereco_s;
    assign mem_escrever     = (estado_r == ESCREVER);
    assign mem_dado_escrita = buffer_r;
    assign ocupado          = (estado_r != OCIOSO);
    assign pronto           = (estado_r == FIM);
    assign contagem         = contagem_r;

endmodule
